des_round_controller: RTL and testbench
=======================================

// Module: des_round_controller
// PURPOSE
//  Sequencer for the DES round datapath (des_round_computations) and its subkey source.
//  Accepts one 64-bit block request per handshake and latches the encrypt/decrypt mode.
//  Pulses des_start for one cycle, then holds des_enable for NUM_ROUNDS cycles while driving the subkey round index.
//  Presents out_valid until downstream (swap/final-permutation stage) takes the result.
// PARAMETERS
//  NUM_ROUNDS  16  rounds per block; reduced values for bench only; must be >= 2
//  CNT_W       4   round counter width, = $clog2(NUM_ROUNDS)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  req_valid   in   1      upstream has a block in des_in (datapath input, not routed here)
//  req_ready   out  1      controller accepts request this cycle
//  req_mode    in   1      0 = encrypt, 1 = decrypt; sampled on accept
//  out_valid   out  1      des_curr holds final round result
//  out_ready   in   1      downstream consumes result
//  des_start   out  1      to datapath: load des_in
//  des_enable  out  1      to datapath: execute one round
//  key_load    out  1      to key schedule: load key and mode (same cycle as des_start)
//  key_round   out  CNT_W  subkey index for the current round
//  busy        out  1      high in any state except IDLE
//  abort       in   1      present only with DES_CTRL_ABORT_EN
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, round_cnt=0, mode_q=0.
//   All outputs low except req_ready=1. Reset mid-block discards the block with no out_valid.
//  FSM states IDLE, LOAD, ROUND, DONE:
//   IDLE : req_ready=1; req_valid -> LOAD, mode_q<=req_mode.
//   LOAD : des_start=1, key_load=1 for exactly one cycle; round_cnt<=0; -> ROUND.
//   ROUND: des_enable=1; round_cnt++ each cycle.
//          round_cnt==NUM_ROUNDS-1 -> DONE; round_cnt<=0.
//   DONE : out_valid=1, held stable until out_ready.
//          out_ready & req_valid -> LOAD (back-to-back, new mode latched).
//          out_ready & !req_valid -> IDLE.
//  req_ready = (state==IDLE) | (state==DONE & out_ready); combinational on out_ready only.
//  des_start and des_enable are never high in the same cycle.
//  key_round (ROUND only, else 0):
//   mode_q=0 -> round_cnt; mode_q=1 -> NUM_ROUNDS-1-round_cnt.
//   Subkey source is combinational on key_round.
//  Latency: accept at cycle T; des_start at T+1; des_enable at T+2..T+1+NUM_ROUNDS.
//   out_valid from T+2+NUM_ROUNDS. Throughput with out_ready=1: one block per NUM_ROUNDS+2 cycles.
//  req_valid while busy: ignored (req_ready=0); upstream holds des_in and req_valid.
//  Counter never wraps; round_cnt is only compared against NUM_ROUNDS-1, unsigned.
// CONFIGURATION
//  DES_CTRL_ABORT_EN defined:
//   abort port exists; abort=1 in LOAD/ROUND/DONE -> IDLE next cycle, round_cnt<=0, no out_valid.
//   abort beats out_ready and req_valid in the same cycle; abort in IDLE has no effect.
//  Undefined: no abort port; a block runs to completion once accepted.
// STRUCTURE
//  des_pkg: typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} des_ctrl_state_t;
//   localparam DES_ROUNDS=16; DES_MODE_ENC=1'b0, DES_MODE_DEC=1'b1.
//  No sub-module: single registered FSM, round counter and mode register, combinational outputs.
// TESTING
//  1 Reset, req_valid=1, mode=0, out_ready=1:
//    des_start only at T+1; des_enable 16 cycles; key_round 0..15; out_valid at T+18 for 1 cycle.
//  2 mode=1: key_round 15..0 during ROUND.
//    Datapath check: pt 0x0123456789ABCDEF, key 0x133457799BBCDFF1 -> ct 0x85E813540F0AB405 (after swap/FP).
//  3 out_ready=0 for 5 cycles in DONE:
//    out_valid held, req_ready=0, des_enable=0; then out_ready=1 with req_valid=1 -> des_start next cycle.
//  4 rst=1 at ROUND cycle 7:
//    next cycle IDLE, req_ready=1, des_enable=0, no out_valid ever for that block.
//  5 DES_CTRL_ABORT_EN, abort at ROUND cycle 3:
//    IDLE next cycle; new request completes normally with key_round starting at 0.
//  6 Back-to-back 3 blocks, alternating modes, req_valid/out_ready=1: out_valid every 18 cycles.
//    des_start/des_enable never overlap.

Source files
------------

// File: rtl/des_round_controller_pkg.sv
// Shared types and constants for the DES round controller.
// Contents: FSM state type, default round count and mode encodings.
package des_round_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } des_ctrl_state_t;

    localparam int unsigned DES_ROUNDS   = 16;
    localparam logic        DES_MODE_ENC = 1'b0;
    localparam logic        DES_MODE_DEC = 1'b1;

endpackage

// File: rtl/des_round_controller_if.sv
// Request/result handshake bundle between the DES controller and its
// upstream (block source) and downstream (swap/final-permutation) stages.
// Signals:
//   req_valid  upstream has a block ready on the datapath input
//   req_ready  controller accepts the request this cycle
//   req_mode   0 = encrypt, 1 = decrypt, sampled on accept
//   out_valid  final round result is available
//   out_ready  downstream consumes the result
// Modports: master = upstream/downstream side, slave = controller.
interface des_round_controller_if;

    logic req_valid;
    logic req_ready;
    logic req_mode;
    logic out_valid;
    logic out_ready;

    modport master (
        output req_valid,
        output req_mode,
        output out_ready,
        input  req_ready,
        input  out_valid
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        input  out_ready,
        output req_ready,
        output out_valid
    );

endinterface

// File: rtl/des_round_controller.sv
// Sequencer for the DES round datapath and its subkey source.
// Accepts one block per handshake, pulses des_start/key_load for one cycle,
// holds des_enable for NUM_ROUNDS cycles while driving the subkey index, then
// presents out_valid until downstream takes the result.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bus         handshake bundle (slave side)
//   des_start   datapath load pulse
//   des_enable  datapath round enable
//   key_load    key schedule load pulse (same cycle as des_start)
//   key_round   subkey index, reversed for decrypt, 0 outside ROUND
//   busy        high in any state except IDLE
//   abort       only when DES_CTRL_ABORT_EN is defined: drop the current block
// Optional feature macro: DES_CTRL_ABORT_EN.
module des_round_controller
    import des_round_controller_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = DES_ROUNDS,
    parameter int unsigned CNT_W      = $clog2(NUM_ROUNDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    des_round_controller_if.slave bus,
    output logic                 des_start,
    output logic                 des_enable,
    output logic                 key_load,
    output logic [CNT_W-1:0]     key_round,
    output logic                 busy
`ifdef DES_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

    des_ctrl_state_t  state;
    logic [CNT_W-1:0] round_cnt;
    logic             mode_q;
    logic             abort_hit;

`ifdef DES_CTRL_ABORT_EN
    // Abort has no effect in IDLE, so it can never block a fresh accept there.
    assign abort_hit = abort & (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= '0;
            mode_q    <= DES_MODE_ENC;
        end else if (abort_hit) begin
            state     <= IDLE;
            round_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state  <= LOAD;
                        mode_q <= bus.req_mode;
                    end
                end
                LOAD: begin
                    round_cnt <= '0;
                    state     <= ROUND;
                end
                ROUND: begin
                    if (round_cnt == LAST_CNT) begin
                        round_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        round_cnt <= round_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.req_valid) begin
                            state  <= LOAD;
                            mode_q <= bus.req_mode;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from the state register, so start and enable are
    // mutually exclusive by construction.
    assign des_start     = (state == LOAD);
    assign key_load      = (state == LOAD);
    assign des_enable    = (state == ROUND);
    assign bus.out_valid = (state == DONE);
    assign busy          = (state != IDLE);

    // In DONE a request is only taken when the result leaves the same cycle.
    assign bus.req_ready = (state == IDLE) |
                           ((state == DONE) & bus.out_ready & ~abort_hit);

    always_comb begin
        key_round = '0;
        if (state == ROUND) begin
            key_round = (mode_q == DES_MODE_DEC) ? (LAST_CNT - round_cnt) : round_cnt;
        end
    end

endmodule

// File: tb/tb_des_round_controller.sv
module tb_des_round_controller;

    localparam int N  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          des_start, des_enable, key_load, busy;
    logic [CW-1:0] key_round;
    logic          abort = 1'b0;

    des_round_controller_if bus ();

    always #5 clk = ~clk;

    des_round_controller #(
        .NUM_ROUNDS (N),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .des_start  (des_start),
        .des_enable (des_enable),
        .key_load   (key_load),
        .key_round  (key_round),
        .busy       (busy)
`ifdef DES_CTRL_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got timeout expected event (t=%0t)", name, $time);
    endtask

    // Reference model: a block is described by its age in cycles since accept.
    // Age 1 is the load cycle, ages 2..N+1 are the rounds, age N+2 is the
    // result-waiting period; age 0 means no block is in flight.
    int m_age  = 0;
    bit m_mode = 1'b0;
    bit m_live = 1'b0;

    function automatic bit ab_eff(int age, bit ab);
`ifdef DES_CTRL_ABORT_EN
        return (age != 0) && ab;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready(int age, bit ordy, bit ab);
        return (age == 0) || ((age == N + 2) && ordy && !ab_eff(age, ab));
    endfunction

    function automatic int next_age(int age, bit rv, bit ordy, bit ab);
        if (ab_eff(age, ab)) return 0;
        if (age == 0) return rv ? 1 : 0;
        if (age < N + 2) return age + 1;
        if (ordy) return rv ? 1 : 0;
        return N + 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_age  <= 0;
            m_mode <= 1'b0;
            m_live <= 1'b1;
        end else begin
            m_age <= next_age(m_age, bus.req_valid, bus.out_ready, abort);
            if (bus.req_valid && m_ready(m_age, bus.out_ready, abort)) m_mode <= bus.req_mode;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_des_start", des_start, m_age == 1);
            chk("m_key_load", key_load, m_age == 1);
            chk("m_des_enable", des_enable, (m_age >= 2) && (m_age <= N + 1));
            chk("m_key_round", key_round,
                ((m_age >= 2) && (m_age <= N + 1)) ?
                (m_mode ? (N - 1 - (m_age - 2)) : (m_age - 2)) : 0);
            chk("m_out_valid", bus.out_valid, m_age == N + 2);
            chk("m_busy", busy, m_age != 0);
            chk("m_req_ready", bus.req_ready, m_ready(m_age, bus.out_ready, abort));
            chk("no_overlap", des_start & des_enable, 0);
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail(name);
    endtask

    task automatic wait_out_valid(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        fail(name);
    endtask

    // Runs one block from IDLE with out_ready low, stalls in DONE, then consumes.
    // With reaccept, a new request of the opposite mode is offered on consume.
    task automatic run_block(input bit mode, input int stall, input bit reaccept,
                             output int fk, output int lk, output int lat,
                             output int nen, output int nst);
        bit got = 1'b0;
        fk = -1; lk = -1; lat = 0; nen = 0; nst = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_mode = mode; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (des_start) nst++;
            if (des_enable) begin
                if (nen == 0) fk = int'(key_round);
                lk = int'(key_round);
                nen++;
            end
            if (bus.out_valid) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("out_valid_timeout");
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_des_enable", des_enable, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.req_valid = reaccept;
        bus.req_mode  = ~mode;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        if (reaccept) begin
            chk("reaccept_des_start", des_start, 1);
            chk("reaccept_key_load", key_load, 1);
        end else begin
            chk("consume_busy", busy, 0);
        end
    endtask

    task automatic drain();
        wait_out_valid("drain_timeout");
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        wait_idle("drain_idle");
    endtask

    typedef struct {
        bit mode;
        int stall;
        int first_key;
        int last_key;
        int lat;
        int n_en;
        int n_st;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fk, lk, lat, nen, nst;
        int ov_cyc[$];
        int starts;
        bit flip;

        vecs[0] = '{mode: 1'b0, stall: 0, first_key: 0,  last_key: 15, lat: 18, n_en: 16, n_st: 1};
        vecs[1] = '{mode: 1'b1, stall: 0, first_key: 15, last_key: 0,  lat: 18, n_en: 16, n_st: 1};
        vecs[2] = '{mode: 1'b0, stall: 5, first_key: 0,  last_key: 15, lat: 18, n_en: 16, n_st: 1};
        vecs[3] = '{mode: 1'b1, stall: 3, first_key: 15, last_key: 0,  lat: 18, n_en: 16, n_st: 1};

        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_des_start", des_start, 0);
        chk("rst_des_enable", des_enable, 0);
        chk("rst_key_load", key_load, 0);
        chk("rst_key_round", key_round, 0);
        chk("rst_busy", busy, 0);

        // Table-driven blocks: latency, round count and key order per mode.
        foreach (vecs[v]) begin
            run_block(vecs[v].mode, vecs[v].stall, 1'b0, fk, lk, lat, nen, nst);
            chk("vec_first_key", fk, vecs[v].first_key);
            chk("vec_last_key", lk, vecs[v].last_key);
            chk("vec_latency", lat, vecs[v].lat);
            chk("vec_enable_cycles", nen, vecs[v].n_en);
            chk("vec_start_pulses", nst, vecs[v].n_st);
        end

        // Stall 5 cycles in DONE, then consume and re-accept in the same cycle.
        run_block(1'b0, 5, 1'b1, fk, lk, lat, nen, nst);
        chk("reacc_latency", lat, 18);
        drain();

        // Synchronous reset in the middle of the rounds drops the block.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_mode = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        nen = 0;
        for (int i = 0; i < 40 && nen < 7; i++) begin
            @(negedge clk);
            if (des_enable) nen++;
        end
        chk("rst_mid_enables", nen, 7);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", bus.req_ready, 1);
        chk("rst_mid_des_enable", des_enable, 0);
        chk("rst_mid_busy", busy, 0);
        nst = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) nst++;
        end
        chk("rst_mid_no_out_valid", nst, 0);
        @(posedge clk); #1 bus.out_ready = 1'b0;

`ifdef DES_CTRL_ABORT_EN
        // Abort during round 3, then a fresh block must start from key index 0.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_mode = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        nen = 0;
        for (int i = 0; i < 40 && nen < 3; i++) begin
            @(negedge clk);
            if (des_enable) nen++;
        end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", bus.req_ready, 1);
        run_block(1'b0, 0, 1'b0, fk, lk, lat, nen, nst);
        chk("abort_next_first_key", fk, 0);
        chk("abort_next_latency", lat, 18);
`endif

        // Back-to-back blocks with alternating modes and out_ready held high.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_mode = 1'b0; bus.out_ready = 1'b1;
        starts = 0;
        flip = 1'b0;
        for (int c = 0; c < 100 && ov_cyc.size() < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid) ov_cyc.push_back(c);
            if (des_start) begin
                starts++;
                flip = 1'b1;
            end
            @(posedge clk); #1;
            if (flip) begin
                bus.req_mode = ~bus.req_mode;
                flip = 1'b0;
            end
            if (starts >= 3) bus.req_valid = 1'b0;
        end
        chk("b2b_results", ov_cyc.size(), 3);
        if (ov_cyc.size() >= 3) begin
            chk("b2b_gap1", ov_cyc[1] - ov_cyc[0], 18);
            chk("b2b_gap2", ov_cyc[2] - ov_cyc[1], 18);
        end
        chk("b2b_starts", starts, 3);
        wait_idle("b2b_idle");
        @(posedge clk); #1 bus.out_ready = 1'b0;

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_mode  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 1) == 1);
            rst           = ($urandom_range(0, 199) == 0);
`ifdef DES_CTRL_ABORT_EN
            abort         = ($urandom_range(0, 99) == 0);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        bus.req_valid = 1'b0; bus.out_ready = 1'b1;
        wait_idle("rand_idle");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
